imem_loader: RTL and testbench

Boot-time instruction loader upstream of the instruction memory. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and issues one write per word into the instruction memory's write port. It holds the single-cycle core in reset until the whole program has loaded. Stream format: 16-bit little-endian word count N, then N×4 instruction bytes, least-significant byte first.

---
 rtl/imem_loader.sv | 137 +++++++++++++
 tb/tb_imem_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction loader.
// Takes a byte stream (16-bit LE word count N, then N little-endian 32-bit
// words), writes each assembled word into the instruction memory, and holds
// the core in reset until the whole program has loaded.
module imem_loader #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_reset,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_e;

    // Largest legal word count; compared at 17 bits so N = 0xFFFF cannot alias.
    localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

    state_e                state_q, state_d;
    logic [15:0]           n_q, n_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;

    logic                  xfer;
    logic [15:0]           n_full;
    logic                  last_word;

    assign xfer      = rx_valid & rx_ready;
    assign n_full    = {rx_data, n_q[7:0]};
    assign last_word = (16'(word_count_q) + 16'd1) == n_q;

    // State register.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_LEN_LO;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: advances on byte transfers, WRITE always lasts one cycle.
    // NOTE: the default assignment up front keeps every path assigned, so no
    // latch is inferred for the branches that do not mention state_d.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LEN_LO: if (xfer) state_d = S_LEN_HI;
            S_LEN_HI: begin
                if (xfer) begin
                    if (n_full == 16'd0)                  state_d = S_DONE;
                    else if ({1'b0, n_full} > CAPACITY)   state_d = S_ERR;
                    else                                  state_d = S_DATA;
                end
            end
            S_DATA:   if (xfer && byte_idx_q == 2'd3) state_d = S_WRITE;
            S_WRITE:  state_d = last_word ? S_DONE : S_DATA;
            S_DONE:   state_d = S_DONE;
            S_ERR:    state_d = S_ERR;
            default:  state_d = S_LEN_LO;
        endcase
    end

    // Output decode: everything comes straight from the state register.
    always_comb begin
        rx_ready   = !reset && (state_q == S_LEN_LO || state_q == S_LEN_HI ||
                                state_q == S_DATA);
        imem_we    = (state_q == S_WRITE);
        done       = (state_q == S_DONE);
        error      = (state_q == S_ERR);
        core_reset = (state_q != S_DONE);
    end

    // Datapath next values: length capture, byte assembly, write address and count.
    always_comb begin
        n_d          = n_q;
        byte_idx_d   = byte_idx_q;
        word_count_d = word_count_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        case (state_q)
            S_LEN_LO: if (xfer) n_d[7:0]  = rx_data;
            S_LEN_HI: if (xfer) n_d[15:8] = rx_data;
            S_DATA: begin
                if (xfer) begin
                    wdata_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
                    // 2-bit index wraps 3 -> 0 as the word completes.
                    byte_idx_d = byte_idx_q + 2'd1;
                    // Address is latched as WRITE is entered so it holds afterwards.
                    if (byte_idx_q == 2'd3) addr_d = word_count_q[ADDR_WIDTH-1:0];
                end
            end
            S_WRITE:  word_count_d = word_count_q + 1'b1;
            default:  ;
        endcase
    end

    // Datapath registers; a mid-load reset discards any partial word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_q          <= '0;
            byte_idx_q   <= '0;
            word_count_q <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            n_q          <= n_d;
            byte_idx_q   <= byte_idx_d;
            word_count_q <= word_count_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized byte streams and gaps,
// compared cycle by cycle against a stream-level reference model.
module tb_imem_loader;

    localparam int AW  = 6;
    localparam int CAP = 1 << AW;

    typedef logic [7:0] byte_q_t[$];

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_reset;
    logic          done;
    logic          error;
    logic [AW:0]   word_count;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: tracks the stream in terms of bytes accepted, the
    // declared length, and words written. Also records what memory received.
    int          m_nbytes, m_n, m_writes, cyc;
    logic [7:0]  m_nlo;
    bit          m_we, m_done, m_err;
    logic [31:0] m_wdata;
    logic [AW-1:0] m_addr;
    logic [31:0] seen_mem [CAP];
    int          we_pulses;
    int          we_cycle [CAP];

    always @(negedge clk) begin
        bit exp_ready;
        int k;
        cyc++;
        if (reset) begin
            m_nbytes = 0; m_n = 0; m_writes = 0; m_nlo = 0;
            m_we = 0; m_done = 0; m_err = 0; m_wdata = 0; m_addr = 0;
            we_pulses = 0;
            for (int i = 0; i < CAP; i++) seen_mem[i] = 32'hDEAD_BEEF;
            check("rst_rx_ready",   rx_ready,   0);
            check("rst_imem_we",    imem_we,    0);
            check("rst_imem_addr",  imem_addr,  0);
            check("rst_imem_wdata", imem_wdata, 0);
            check("rst_word_count", word_count, 0);
            check("rst_done",       done,       0);
            check("rst_error",      error,      0);
            check("rst_core_reset", core_reset, 1);
        end else begin
            exp_ready = !m_we && !m_done && !m_err;
            check("rx_ready",   rx_ready,   exp_ready);
            check("imem_we",    imem_we,    m_we);
            check("imem_addr",  imem_addr,  m_addr);
            check("imem_wdata", imem_wdata, m_wdata);
            check("word_count", word_count, m_writes);
            check("done",       done,       m_done);
            check("error",      error,      m_err);
            check("core_reset", core_reset, !m_done);
            if (imem_we === 1'b1) begin
                seen_mem[imem_addr] = imem_wdata;
                if (we_pulses < CAP) we_cycle[we_pulses] = cyc;
                we_pulses++;
            end
            // Advance the model to what the next rising edge should produce.
            if (m_we) begin
                m_we = 0;
                m_writes++;
                if (m_writes == m_n) m_done = 1;
            end else if (exp_ready && rx_valid) begin
                m_nbytes++;
                if (m_nbytes == 1) begin
                    m_nlo = rx_data;
                end else if (m_nbytes == 2) begin
                    m_n = int'(rx_data) * 256 + int'(m_nlo);
                    if (m_n == 0)        m_done = 1;
                    else if (m_n > CAP)  m_err  = 1;
                end else begin
                    k = (m_nbytes - 3) % 4;
                    m_wdata[8*k +: 8] = rx_data;
                    if (k == 3) begin
                        m_we   = 1;
                        m_addr = AW'((m_nbytes - 3) / 4);
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc;
        repeat (gap) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        acc = 0;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk);
            acc = rx_ready;
            @(posedge clk); #1;
        end
        check("byte_accepted", acc, 1);
        rx_valid = 1'b0;
    endtask

    task automatic send_stream(input byte_q_t bytes, input int min_gap, input int max_gap);
        foreach (bytes[i]) send_byte(bytes[i], int'($urandom_range(max_gap, min_gap)));
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        reset    = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Random program of n words; verifies what memory received and the final flags.
    task automatic load_random(input int n, input int min_gap, input int max_gap);
        byte_q_t     q;
        logic [31:0] words [CAP];
        q = {};
        q.push_back(8'(n));
        q.push_back(8'(n >> 8));
        for (int i = 0; i < n; i++) begin
            words[i] = $urandom;
            for (int b = 0; b < 4; b++) q.push_back(words[i][8*b +: 8]);
        end
        send_stream(q, min_gap, max_gap);
        idle(3);
        check("load_done",       done,       1);
        check("load_core_reset", core_reset, 0);
        check("load_word_count", word_count, n);
        check("load_we_pulses",  we_pulses,  n);
        for (int i = 0; i < n; i++) check($sformatf("load_mem[%0d]", i), seen_mem[i], words[i]);
    endtask

    initial begin
        byte_q_t nominal;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Nominal two-word load, rx_valid held high.
        nominal = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        send_stream(nominal, 0, 0);
        idle(3);
        check("nom_mem0",       seen_mem[0], 32'h00A00513);
        check("nom_mem1",       seen_mem[1], 32'h00100593);
        check("nom_we_pulses",  we_pulses,   2);
        check("nom_we_spacing", we_cycle[1] - we_cycle[0], 5);
        check("nom_done",       done,        1);
        check("nom_core_reset", core_reset,  0);
        check("nom_word_count", word_count,  2);

        // Same program with 3 idle cycles before every byte.
        do_reset();
        send_stream(nominal, 3, 3);
        idle(3);
        check("gap_mem0",       seen_mem[0], 32'h00A00513);
        check("gap_mem1",       seen_mem[1], 32'h00100593);
        check("gap_word_count", word_count,  2);

        // Empty program: DONE right after the second length byte.
        do_reset();
        send_stream('{8'h00, 8'h00}, 0, 0);
        check("empty_done",       done,       1);
        check("empty_core_reset", core_reset, 0);
        idle(2);
        check("empty_word_count", word_count, 0);
        check("empty_we_pulses",  we_pulses,  0);

        // Oversize: N = 65 is rejected and trailing bytes are ignored.
        do_reset();
        send_stream('{8'h41, 8'h00}, 0, 0);
        check("over_error",      error,      1);
        check("over_core_reset", core_reset, 1);
        check("over_rx_ready",   rx_ready,   0);
        rx_valid = 1'b1;
        repeat (10) begin rx_data = 8'($urandom); @(posedge clk); #1; end
        rx_valid = 1'b0;
        check("over_we_pulses",  we_pulses,  0);
        check("over_error_held", error,      1);
        check("over_word_count", word_count, 0);

        // Capacity edge: N = 64 fills memory, last write at address 63.
        do_reset();
        load_random(CAP, 0, 1);
        check("cap_word_count", word_count, CAP);

        // Random programs with random gaps.
        for (int t = 0; t < 4; t++) begin
            do_reset();
            load_random(int'($urandom_range(12, 1)), 0, 4);
        end

        // Reset mid-word: abort after 3 bytes of word 1, outputs clear at once.
        do_reset();
        send_stream('{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77}, 0, 0);
        #2 reset = 1'b1;
        #1;
        check("amid_rx_ready",   rx_ready,   0);
        check("amid_imem_we",    imem_we,    0);
        check("amid_imem_addr",  imem_addr,  0);
        check("amid_imem_wdata", imem_wdata, 0);
        check("amid_word_count", word_count, 0);
        check("amid_done",       done,       0);
        check("amid_error",      error,      0);
        check("amid_core_reset", core_reset, 1);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        load_random(1, 0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
